// File: rtl/mv_search_scheduler.sv
// mv_search_scheduler
//   Sequences one full-search motion-estimation pass over a (2R+1)x(2R+1)
//   window around a centre MV. Candidates are issued in raster order
//   (dy outer, dx inner), three per group, to the SAD engine / 3-entry MV
//   selector. After each group it waits for the selector verdict and
//   forwards the group winner on a result stream.
//
// Ports
//   clk, reset        rising-edge clock, async active-low reset
//   start             1-cycle pulse, accepted only when idle
//   abort             level, returns to idle on the next cycle from anywhere
//   center_x/_y       signed centre MV, sampled on an accepted start
//   sad_ready         SAD engine can take a candidate this cycle
//   sel_done, sel_mv  selector verdict pulse and winning MV {x,y}
//   sel_we            candidate issue strobe (registered)
//   sel_mv_out        candidate MV {x,y}, valid with sel_we
//   sel_mvwait        marks the third (last) candidate of a group
//   res_valid         1-cycle pulse, group winner on res_mv / res_idx
//   busy              high whenever not idle
//   pass_done         1-cycle pulse, one cycle after the final res_valid
module mv_search_scheduler #(
    parameter int RANGE = 1,
    parameter int MVW   = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [MVW-1:0]   center_x,
    input  logic [MVW-1:0]   center_y,
    input  logic             sad_ready,
    input  logic             sel_done,
    input  logic [2*MVW-1:0] sel_mv,
    output logic             sel_we,
    output logic [2*MVW-1:0] sel_mv_out,
    output logic             sel_mvwait,
    output logic             res_valid,
    output logic [2*MVW-1:0] res_mv,
    output logic [7:0]       res_idx,
    output logic             busy,
    output logic             pass_done
);

    localparam int SIDE   = 2*RANGE + 1;
    localparam int GROUPS = (SIDE*SIDE) / 3;
    localparam int CW     = $clog2(SIDE);
    // One extra bit is enough because |offset| never exceeds the MV range.
    localparam int SW     = MVW + 1;

    localparam logic signed [SW-1:0] SMAX = SW'((2**(MVW-1)) - 1);
    localparam logic signed [SW-1:0] SMIN = SW'(-(2**(MVW-1)));

    // The window must split into whole groups of three, the group index
    // must fit 8 bits, and the offset must fit the widened sum.
    generate
        if ((SIDE % 3) != 0 || GROUPS > 256 || RANGE < 1 || RANGE >= 2**(MVW-1)) begin : g_bad_params
            $error("mv_search_scheduler: illegal RANGE/MVW combination");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_EMIT,
        S_DONE
    } state_t;

    state_t         state;
    logic [MVW-1:0] cx, cy;
    logic [CW-1:0]  ix, iy;     // window position, 0..SIDE-1 each
    logic [1:0]     slot;       // candidate slot within the current group
    logic [7:0]     idx;        // current group index

    // centre + (i - RANGE), clamped to the signed MV range instead of wrapping
    function automatic logic [MVW-1:0] sat_add(input logic [MVW-1:0] c,
                                               input logic [CW-1:0]  i);
        logic signed [SW-1:0] base;
        logic signed [SW-1:0] off;
        logic signed [SW-1:0] sum;
        base = SW'($signed(c));
        off  = $signed(SW'(i)) - $signed(SW'(RANGE));
        sum  = base + off;
        if (sum > SMAX)
            sum = SMAX;
        else if (sum < SMIN)
            sum = SMIN;
        return sum[MVW-1:0];
    endfunction

    logic [2*MVW-1:0] cand;
    assign cand = {sat_add(cx, ix), sat_add(cy, iy)};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            cx         <= '0;
            cy         <= '0;
            ix         <= '0;
            iy         <= '0;
            slot       <= '0;
            idx        <= '0;
            sel_we     <= 1'b0;
            sel_mv_out <= '0;
            sel_mvwait <= 1'b0;
            res_valid  <= 1'b0;
            res_mv     <= '0;
            res_idx    <= '0;
            busy       <= 1'b0;
            pass_done  <= 1'b0;
        end else begin
            // strobes are single-cycle unless re-asserted below
            sel_we     <= 1'b0;
            sel_mvwait <= 1'b0;
            res_valid  <= 1'b0;
            pass_done  <= 1'b0;

            if (abort) begin
                // abort beats start, sel_done and everything else
                state      <= S_IDLE;
                busy       <= 1'b0;
                sel_mv_out <= '0;
                res_mv     <= '0;
                res_idx    <= '0;
                ix         <= '0;
                iy         <= '0;
                slot       <= '0;
                idx        <= '0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            cx    <= center_x;
                            cy    <= center_y;
                            ix    <= '0;
                            iy    <= '0;
                            slot  <= '0;
                            idx   <= '0;
                            busy  <= 1'b1;
                            state <= S_ISSUE;
                        end
                    end

                    S_ISSUE: begin
                        // a stalled engine freezes position and slot
                        if (sad_ready) begin
                            sel_we     <= 1'b1;
                            sel_mv_out <= cand;
                            sel_mvwait <= (slot == 2'd2);
                            if (ix == CW'(SIDE-1)) begin
                                ix <= '0;
                                iy <= (iy == CW'(SIDE-1)) ? '0 : iy + CW'(1);
                            end else begin
                                ix <= ix + CW'(1);
                            end
                            if (slot == 2'd2) begin
                                slot  <= '0;
                                state <= S_WAIT;
                            end else begin
                                slot  <= slot + 2'd1;
                            end
                        end
                    end

                    S_WAIT: begin
                        // winner is latched straight into the result register
                        if (sel_done) begin
                            res_valid <= 1'b1;
                            res_mv    <= sel_mv;
                            res_idx   <= idx;
                            state     <= S_EMIT;
                        end
                    end

                    S_EMIT: begin
                        idx <= idx + 8'd1;
                        if (idx == 8'(GROUPS-1)) begin
                            pass_done <= 1'b1;
                            state     <= S_DONE;
                        end else begin
                            state     <= S_ISSUE;
                        end
                    end

                    S_DONE: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end

                    default: begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mv_search_scheduler.sv
// Testbench for mv_search_scheduler (RANGE=1, MVW=7).
// Table of passes with hand-computed candidate constants, plus a queue-based
// reference model of the raster/saturation order and a random selector.
module tb_mv_search_scheduler;

    localparam int R    = 1;
    localparam int MVW  = 7;
    localparam int TOT  = (2*R+1)*(2*R+1);
    localparam int GRP  = TOT/3;

    logic        clk = 1'b0;
    logic        reset, start, abort, sad_ready, sel_done;
    logic [6:0]  center_x, center_y;
    logic [13:0] sel_mv;
    logic        sel_we, sel_mvwait, res_valid, busy, pass_done;
    logic [13:0] sel_mv_out, res_mv;
    logic [7:0]  res_idx;

    int cmp = 0;
    int mis = 0;
    logic [13:0] obs [0:8];

    always #5 clk = ~clk;

    mv_search_scheduler #(.RANGE(R), .MVW(MVW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .center_x(center_x), .center_y(center_y),
        .sad_ready(sad_ready), .sel_done(sel_done), .sel_mv(sel_mv),
        .sel_we(sel_we), .sel_mv_out(sel_mv_out), .sel_mvwait(sel_mvwait),
        .res_valid(res_valid), .res_mv(res_mv), .res_idx(res_idx),
        .busy(busy), .pass_done(pass_done)
    );

    typedef struct {
        logic [6:0]  cx;
        logic [6:0]  cy;
        int          mode;    // 0 always ready, 1 toggling, 2 random
        logic [13:0] first;
        logic [13:0] third;
        logic [13:0] last;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        cmp++;
        if (act !== exp) begin
            mis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] clamp(input int v);
        int r;
        r = v;
        if (r > 63) r = 63;
        else if (r < -64) r = -64;
        return 7'(r);
    endfunction

    // One pass; abort_grp>=0 aborts in the WAIT after that group's last
    // candidate; noise injects starts while busy and a stray sel_done.
    task automatic run_pass(input logic [6:0] cx, input logic [6:0] cy, input int mode,
                            input int abort_grp, input bit noise);
        logic [13:0] expq [$];
        logic [13:0] wins [$];
        int  n = 0, g = 0, pd = 0, timer = 0, after_abort = 0;
        bit  prev_ready = 0, aborted = 0, done = 0, stray = 0, s4 = 0, s6 = 0, idle_chk = 0;
        for (int dy = -R; dy <= R; dy++)
            for (int dx = -R; dx <= R; dx++)
                expq.push_back({clamp($signed(cx) + dx), clamp($signed(cy) + dy)});
        for (int i = 0; i < 9; i++) obs[i] = '0;

        @(negedge clk);
        center_x = cx; center_y = cy; start = 1; abort = 0; sel_done = 0; sad_ready = 0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            @(negedge clk);
            if (idle_chk) begin
                chk("busy_after_pass", busy, 0);
                done = 1;
            end
            if (sel_we) begin
                chk("we_needs_ready", prev_ready, 1);
                if (aborted) chk("we_after_abort", sel_we, 0);
                else if (n < TOT) begin
                    chk($sformatf("cand%0d", n), sel_mv_out, expq[n]);
                    chk($sformatf("mvwait%0d", n), sel_mvwait, (n % 3 == 2));
                    obs[n] = sel_mv_out;
                end else chk("we_extra", sel_we, 0);
                if (sel_mvwait) timer = 4;
                n++;
            end
            if (res_valid) begin
                if (aborted || g >= wins.size()) chk("res_unexpected", res_valid, 0);
                else begin
                    chk($sformatf("res_idx%0d", g), res_idx, g);
                    chk($sformatf("res_mv%0d", g), res_mv, wins[g]);
                end
                g++;
            end
            if (pass_done) begin
                pd++;
                if (aborted) chk("pd_after_abort", pass_done, 0);
                else begin
                    chk("pd_all_groups", g, GRP);
                    chk("pd_busy", busy, 1);
                end
                idle_chk = 1;
            end
            if (aborted) begin
                if (after_abort == 0) begin
                    chk("abort_busy", busy, 0);
                    chk("abort_we", sel_we, 0);
                    chk("abort_res", res_valid, 0);
                    chk("abort_mvout", sel_mv_out, 0);
                end
                after_abort++;
                if (after_abort > 20) done = 1;
            end

            // drive next cycle
            start = 0; abort = 0; sel_done = 0;
            if (timer > 0) begin
                timer--;
                if (timer == 0) begin
                    sel_mv = 14'($urandom());
                    wins.push_back(sel_mv);
                    sel_done = 1;
                end
            end
            if (noise && n == 1 && !stray && !sel_done) begin
                sel_done = 1; sel_mv = 14'h2AAA; stray = 1;
            end
            if (noise && ((n == 4 && !s4) || (n == 6 && !s6))) begin
                if (n == 4) s4 = 1; else s6 = 1;
                start = 1; center_x = 7'h15; center_y = 7'h2A;
            end
            if (abort_grp >= 0 && !aborted && n == 3*(abort_grp+1)) begin
                abort = 1; aborted = 1;
            end
            case (mode)
                0:       sad_ready = 1;
                1:       sad_ready = (cyc % 2 == 0);
                default: sad_ready = 1'($urandom_range(0, 1));
            endcase
            prev_ready = sad_ready;
        end
        start = 0; abort = 0; sel_done = 0; sad_ready = 0;
        if (!done) begin
            cmp++; mis++;
            $display("FAIL pass_timeout: n=%0d g=%0d pd=%0d, expected pass end", n, g, pd);
        end
        if (abort_grp >= 0) begin
            chk("abort_n", n, 3*(abort_grp+1));
            chk("abort_groups", g, abort_grp);
            chk("abort_no_pd", pd, 0);
        end else begin
            chk("pass_n", n, TOT);
            chk("pass_groups", g, GRP);
            chk("pass_pd", pd, 1);
        end
    endtask

    initial begin
        int seen;
        reset = 0; start = 0; abort = 0; sad_ready = 0; sel_done = 0; sel_mv = '0;
        center_x = '0; center_y = '0;

        tbl[0] = '{7'h00, 7'h00, 0, 14'h3FFF, 14'h00FF, 14'h0081};
        tbl[1] = '{7'h3F, 7'h40, 0, 14'h1F40, 14'h1FC0, 14'h1FC1};
        tbl[2] = '{7'h40, 7'h3F, 1, 14'h203E, 14'h20BE, 14'h20BF};
        tbl[3] = '{7'h0A, 7'h7B, 2, 14'h04FA, 14'h05FA, 14'h05FC};

        #1;
        chk("rst_we", sel_we, 0);
        chk("rst_mvout", sel_mv_out, 0);
        chk("rst_mvwait", sel_mvwait, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_mv", res_mv, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_pass_done", pass_done, 0);
        @(negedge clk);
        reset = 1;

        for (int t = 0; t < 4; t++) begin
            run_pass(tbl[t].cx, tbl[t].cy, tbl[t].mode, -1, 0);
            chk($sformatf("tbl%0d_first", t), obs[0], tbl[t].first);
            chk($sformatf("tbl%0d_third", t), obs[2], tbl[t].third);
            chk($sformatf("tbl%0d_last", t), obs[8], tbl[t].last);
        end

        // abort in the second WAIT
        run_pass(7'h00, 7'h00, 0, 1, 0);

        // start and abort together while idle, then a stray sel_done while idle
        @(negedge clk);
        start = 1; abort = 1; sad_ready = 1;
        @(negedge clk);
        start = 0; abort = 0;
        chk("start_abort_busy", busy, 0);
        sel_done = 1; sel_mv = 14'h1234;
        @(negedge clk);
        sel_done = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("idle_quiet", {busy, sel_we, res_valid, pass_done}, 4'b0);
        end
        sad_ready = 0;

        // start while busy and stray sel_done in ISSUE
        run_pass(7'h00, 7'h00, 0, -1, 1);

        // async reset in the middle of ISSUE
        @(negedge clk);
        center_x = 7'h03; center_y = 7'h03; start = 1; sad_ready = 1;
        @(negedge clk);
        start = 0;
        seen = 0;
        for (int k = 0; k < 50 && seen < 2; k++) begin
            @(negedge clk);
            if (sel_we) seen++;
        end
        chk("mid_reset_reached", seen, 2);
        reset = 0;
        #1;
        chk("mid_rst_we", sel_we, 0);
        chk("mid_rst_mvout", sel_mv_out, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_res", {res_valid, pass_done, sel_mvwait}, 3'b0);
        sad_ready = 0;
        @(negedge clk);
        reset = 1;
        run_pass(7'h05, 7'h79, 2, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end

endmodule
